scan_job_scheduler: RTL and testbench

- Accepts scan jobs from the host-side job feeder. Splits each job's nonce space into NUM_SCANNERS contiguous slices and starts each scanner on its slice, one per cycle, as soon as that scanner reports ready.
- Aggregates the per-scanner status bundles (dispatching, evaluating, ready) into a hash counter, an activity LED and global idle/busy flags.
- Sits between the job input path and the array of scanner instances.

---
 rtl/scan_job_scheduler_if.sv | 31 +++
 rtl/scan_job_scheduler.sv | 86 ++++++++
 tb/tb_scan_job_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_job_scheduler_if.sv
// scan_job_scheduler_if: job feed, scanner control and status bundle between the host path and the scheduler.
interface scan_job_scheduler_if #(
    parameter int NUM_SCANNERS = 4,
    parameter int CNT_W = 48
);
    logic job_valid;
    logic job_ready;
    logic [7:0] job_id;
    logic [31:0] job_nonce_base;
    logic abort;
    logic [NUM_SCANNERS-1:0] sc_ready;
    logic [NUM_SCANNERS-1:0] sc_dispatching;
    logic [NUM_SCANNERS-1:0] sc_evaluating;
    logic [NUM_SCANNERS-1:0] scan_start;
    logic [31:0] scan_nonce_base;
    logic [7:0] scan_job_id;
    logic cnt_clear;
    logic [CNT_W-1:0] hash_count;
    logic led_activity;
    logic all_idle;
    logic issuing;

    modport master (
        output job_valid, job_id, job_nonce_base, abort, sc_ready, sc_dispatching, sc_evaluating, cnt_clear,
        input job_ready, scan_start, scan_nonce_base, scan_job_id, hash_count, led_activity, all_idle, issuing
    );
    modport slave (
        input job_valid, job_id, job_nonce_base, abort, sc_ready, sc_dispatching, sc_evaluating, cnt_clear,
        output job_ready, scan_start, scan_nonce_base, scan_job_id, hash_count, led_activity, all_idle, issuing
    );
endinterface

// File: rtl/scan_job_scheduler.sv
// scan_job_scheduler: splits each job's nonce space across the scanners, starting them in index order,
// and aggregates scanner status into a saturating hash counter, activity LED and idle/busy flags.
module scan_job_scheduler #(
    parameter int NUM_SCANNERS = 4,
    parameter int SLICE_LOG2 = 28,
    parameter int LED_HOLD = 1 << 22,
    parameter int CNT_W = 48
) (
    input logic clk,
    input logic rst_n,
    scan_job_scheduler_if.slave bus
);
    localparam int IW = NUM_SCANNERS > 1 ? $clog2(NUM_SCANNERS) : 1;
    localparam int PW = $clog2(NUM_SCANNERS + 1);
    localparam int TW = $clog2(LED_HOLD + 1);
    localparam int SW = CNT_W + 5;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t state;
    logic [IW-1:0] idx;
    logic [7:0] id_q;
    logic [31:0] base_q;
    logic [PW-1:0] pop;
    logic [SW-1:0] sum;
    logic [TW-1:0] timer;

    assign bus.job_ready = state == IDLE;
    assign bus.issuing = state == ISSUE;
    assign bus.all_idle = state == IDLE && &bus.sc_ready && !(|bus.sc_dispatching);

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_SCANNERS; i++) pop = pop + PW'(bus.sc_evaluating[i]);
    end

    // Extra headroom bits let the saturation test see the true sum before clamping.
    assign sum = SW'(bus.hash_count) + SW'(pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
            id_q <= '0;
            base_q <= '0;
            bus.scan_start <= '0;
            bus.scan_nonce_base <= '0;
            bus.scan_job_id <= '0;
        end else begin
            bus.scan_start <= '0;
            if (state == IDLE) begin
                if (bus.job_valid) begin
                    id_q <= bus.job_id;
                    base_q <= bus.job_nonce_base;
                    idx <= '0;
                    state <= ISSUE;
                end
            end else if (bus.abort) begin
                state <= IDLE;
            end else if (bus.sc_ready[idx]) begin
                bus.scan_start <= NUM_SCANNERS'(1) << idx;
                bus.scan_nonce_base <= base_q + (32'(idx) << SLICE_LOG2);
                bus.scan_job_id <= id_q;
                idx <= idx + 1'b1;
                if (idx == IW'(NUM_SCANNERS - 1)) state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.hash_count <= '0;
            bus.led_activity <= 1'b0;
            timer <= '0;
        end else begin
            bus.hash_count <= bus.cnt_clear ? '0 : (sum > SW'({CNT_W{1'b1}}) ? '1 : sum[CNT_W-1:0]);
            if (|bus.sc_evaluating) begin
                timer <= TW'(LED_HOLD);
                bus.led_activity <= 1'b1;
            end else begin
                timer <= (timer == '0) ? '0 : timer - 1'b1;
                bus.led_activity <= timer > TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_scan_job_scheduler.sv
// tb_scan_job_scheduler: directed scenarios plus randomized traffic checked against a slice-list model;
// a second narrow-counter instance exercises hash_count saturation.
module tb_scan_job_scheduler;
    localparam int N = 4;
    localparam int SLICE = 28;
    localparam int HOLD = 5;
    localparam longint unsigned MAX48 = (64'd1 << 48) - 1;
    localparam longint unsigned MAX6 = 63;
    localparam logic [31:0] BASIC_B [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    localparam logic [31:0] WRAP_B [4] = '{32'hF000_0000, 32'h0000_0000, 32'h1000_0000, 32'h2000_0000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    scan_job_scheduler_if #(.NUM_SCANNERS(N), .CNT_W(48)) bus ();
    scan_job_scheduler_if #(.NUM_SCANNERS(N), .CNT_W(6)) bus2 ();

    scan_job_scheduler #(.NUM_SCANNERS(N), .SLICE_LOG2(SLICE), .LED_HOLD(HOLD), .CNT_W(48)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    scan_job_scheduler #(.NUM_SCANNERS(N), .SLICE_LOG2(SLICE), .LED_HOLD(HOLD), .CNT_W(6)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    assign bus2.job_valid = 1'b0;
    assign bus2.job_id = 8'h0;
    assign bus2.job_nonce_base = 32'h0;
    assign bus2.abort = 1'b0;
    assign bus2.sc_ready = bus.sc_ready;
    assign bus2.sc_dispatching = bus.sc_dispatching;
    assign bus2.sc_evaluating = bus.sc_evaluating;
    assign bus2.cnt_clear = bus.cnt_clear;

    always #5 clk = ~clk;

    // Reference model: a job is a list of N slices handed out in order whenever the next one's scanner is ready.
    bit m_active;
    int m_next;
    logic [7:0] m_id;
    logic [31:0] m_base;
    logic [N-1:0] e_start;
    logic [31:0] e_base;
    logic [7:0] e_id;
    longint unsigned m_cnt, m_cnt6;
    int m_since;

    task automatic model_step();
        int n;
        if (!rst_n) begin
            m_active = 0; m_next = 0; e_start = '0; e_base = '0; e_id = '0;
            m_cnt = 0; m_cnt6 = 0; m_since = 1000;
        end else begin
            e_start = '0;
            if (!m_active) begin
                if (bus.job_valid) begin
                    m_active = 1; m_id = bus.job_id; m_base = bus.job_nonce_base; m_next = 0;
                end
            end else if (bus.abort) begin
                m_active = 0;
            end else if (bus.sc_ready[m_next]) begin
                e_start = 4'(1 << m_next);
                e_base = 32'(64'(m_base) + 64'(m_next) * (64'd1 << SLICE));
                e_id = m_id;
                m_next++;
                if (m_next == N) m_active = 0;
            end
            n = $countones(bus.sc_evaluating);
            m_cnt = bus.cnt_clear ? 0 : ((m_cnt + n > MAX48) ? MAX48 : m_cnt + n);
            m_cnt6 = bus.cnt_clear ? 0 : ((m_cnt6 + n > MAX6) ? MAX6 : m_cnt6 + n);
            m_since = (n != 0) ? 0 : (m_since < 1000 ? m_since + 1 : m_since);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        bus.job_valid = 1'b0; bus.job_id = 8'h0; bus.job_nonce_base = 32'h0; bus.abort = 1'b0;
        bus.sc_ready = '1; bus.sc_dispatching = '0; bus.sc_evaluating = '0; bus.cnt_clear = 1'b0;
    endtask

    task automatic send_job(input logic [7:0] id, input logic [31:0] base);
        bus.job_valid = 1'b1; bus.job_id = id; bus.job_nonce_base = base;
        tick();
        bus.job_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick(); tick();
        checks++;
        if (bus.scan_start !== 4'b0 || bus.scan_nonce_base !== 32'h0 || bus.scan_job_id !== 8'h0) begin
            errors++; $display("FAIL reset_scan got start=%b base=%h id=%h exp all 0", bus.scan_start, bus.scan_nonce_base, bus.scan_job_id);
        end
        checks++;
        if (bus.hash_count !== 48'h0 || bus.led_activity !== 1'b0) begin
            errors++; $display("FAIL reset_status got cnt=%h led=%b exp 0/0", bus.hash_count, bus.led_activity);
        end
        checks++;
        if (bus.job_ready !== 1'b1 || bus.issuing !== 1'b0 || bus.all_idle !== 1'b1) begin
            errors++; $display("FAIL reset_flags got ready=%b issuing=%b idle=%b exp 1/0/1", bus.job_ready, bus.issuing, bus.all_idle);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send_job(8'h11, 32'h0);
        for (int i = 0; i < N; i++) begin
            tick();
            checks++;
            if (bus.scan_start !== 4'(1 << i) || bus.scan_nonce_base !== BASIC_B[i] || bus.scan_job_id !== 8'h11) begin
                errors++; $display("FAIL basic_strobe%0d got start=%b base=%h id=%h exp %b/%h/11", i, bus.scan_start, bus.scan_nonce_base, bus.scan_job_id, 4'(1 << i), BASIC_B[i]);
            end
            checks++;
            if (bus.job_ready !== (i == N - 1) || bus.issuing !== (i != N - 1)) begin
                errors++; $display("FAIL basic_ready%0d got ready=%b issuing=%b", i, bus.job_ready, bus.issuing);
            end
        end
    endtask

    task automatic test_wrap();
        send_job(8'h5A, 32'hF000_0000);
        for (int i = 0; i < N; i++) begin
            tick();
            checks++;
            if (bus.scan_start !== 4'(1 << i) || bus.scan_nonce_base !== WRAP_B[i] || bus.scan_job_id !== 8'h5A) begin
                errors++; $display("FAIL wrap_strobe%0d got start=%b base=%h id=%h exp %b/%h/5a", i, bus.scan_start, bus.scan_nonce_base, bus.scan_job_id, 4'(1 << i), WRAP_B[i]);
            end
        end
    endtask

    task automatic test_stall();
        bus.sc_ready = 4'b1011;
        send_job(8'h22, 32'h0100_0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.scan_start !== 4'(1 << i) || bus.scan_nonce_base !== 32'h0100_0000 + 32'(i) * 32'h1000_0000) begin
                errors++; $display("FAIL stall_pre%0d got start=%b base=%h", i, bus.scan_start, bus.scan_nonce_base);
            end
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (bus.scan_start !== 4'b0 || bus.job_ready !== 1'b0 || bus.issuing !== 1'b1) begin
                errors++; $display("FAIL stall_wait%0d got start=%b ready=%b issuing=%b exp 0000/0/1", k, bus.scan_start, bus.job_ready, bus.issuing);
            end
        end
        bus.sc_ready = '1;
        for (int i = 2; i < N; i++) begin
            tick();
            checks++;
            if (bus.scan_start !== 4'(1 << i) || bus.scan_nonce_base !== 32'h0100_0000 + 32'(i) * 32'h1000_0000 || bus.scan_job_id !== 8'h22) begin
                errors++; $display("FAIL stall_post%0d got start=%b base=%h id=%h", i, bus.scan_start, bus.scan_nonce_base, bus.scan_job_id);
            end
        end
        checks++;
        if (bus.job_ready !== 1'b1) begin
            errors++; $display("FAIL stall_done got ready=%b exp 1", bus.job_ready);
        end
    endtask

    task automatic test_abort();
        send_job(8'h33, 32'hA000_0000);
        tick(); tick();
        checks++;
        if (bus.scan_start !== 4'b0010) begin
            errors++; $display("FAIL abort_pre got start=%b exp 0010", bus.scan_start);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (bus.scan_start !== 4'b0 || bus.job_ready !== 1'b1) begin
            errors++; $display("FAIL abort_cycle got start=%b ready=%b exp 0000/1", bus.scan_start, bus.job_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.scan_start !== 4'b0) begin
                errors++; $display("FAIL abort_quiet%0d got start=%b exp 0000", k, bus.scan_start);
            end
        end
        send_job(8'h44, 32'h0);
        for (int i = 0; i < N; i++) begin
            tick();
            checks++;
            if (bus.scan_start !== 4'(1 << i) || bus.scan_nonce_base !== BASIC_B[i] || bus.scan_job_id !== 8'h44) begin
                errors++; $display("FAIL abort_newjob%0d got start=%b base=%h id=%h", i, bus.scan_start, bus.scan_nonce_base, bus.scan_job_id);
            end
        end
    endtask

    task automatic test_hash();
        bus.cnt_clear = 1'b1;
        tick();
        bus.cnt_clear = 1'b0;
        checks++;
        if (bus.hash_count !== 48'd0) begin
            errors++; $display("FAIL hash_clear got %0d exp 0", bus.hash_count);
        end
        bus.sc_evaluating = '1;
        tick(); tick(); tick();
        bus.sc_evaluating = '0;
        checks++;
        if (bus.hash_count !== 48'd12 || bus2.hash_count !== 6'd12) begin
            errors++; $display("FAIL hash_three got %0d/%0d exp 12/12", bus.hash_count, bus2.hash_count);
        end
        bus.sc_evaluating = '1; bus.cnt_clear = 1'b1;
        tick();
        bus.sc_evaluating = '0; bus.cnt_clear = 1'b0;
        checks++;
        if (bus.hash_count !== 48'd0) begin
            errors++; $display("FAIL hash_clear_prio got %0d exp 0", bus.hash_count);
        end
        bus.sc_evaluating = '1;
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (bus2.hash_count !== 6'd63 || bus.hash_count !== 48'd80) begin
            errors++; $display("FAIL hash_sat got %0d/%0d exp 63/80", bus2.hash_count, bus.hash_count);
        end
        tick();
        bus.sc_evaluating = '0;
        checks++;
        if (bus2.hash_count !== 6'd63) begin
            errors++; $display("FAIL hash_sat_hold got %0d exp 63", bus2.hash_count);
        end
    endtask

    task automatic test_led();
        bus.sc_evaluating = '0;
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (bus.led_activity !== 1'b0) begin
            errors++; $display("FAIL led_idle got %b exp 0", bus.led_activity);
        end
        bus.sc_evaluating = 4'b0100;
        tick();
        bus.sc_evaluating = '0;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick();
            checks++;
            if (bus.led_activity !== (k < HOLD)) begin
                errors++; $display("FAIL led_hold%0d got %b exp %b", k, bus.led_activity, k < HOLD);
            end
        end
    endtask

    task automatic test_reset_mid_issue();
        bus.sc_evaluating = '1;
        send_job(8'h55, 32'h1234_0000);
        bus.sc_evaluating = '0;
        tick();
        checks++;
        if (bus.scan_start !== 4'b0001 || bus.issuing !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got start=%b issuing=%b exp 0001/1", bus.scan_start, bus.issuing);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.scan_start !== 4'b0 || bus.scan_nonce_base !== 32'h0 || bus.scan_job_id !== 8'h0 ||
            bus.hash_count !== 48'h0 || bus.led_activity !== 1'b0 || bus.job_ready !== 1'b1 || bus.issuing !== 1'b0) begin
            errors++; $display("FAIL rstmid_state got start=%b base=%h id=%h cnt=%0d led=%b ready=%b issuing=%b",
                bus.scan_start, bus.scan_nonce_base, bus.scan_job_id, bus.hash_count, bus.led_activity, bus.job_ready, bus.issuing);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.scan_start !== 4'b0 || bus.job_ready !== 1'b1) begin
                errors++; $display("FAIL rstmid_after%0d got start=%b ready=%b exp 0000/1", k, bus.scan_start, bus.job_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            bus.job_valid = $urandom_range(0, 3) == 0;
            bus.job_id = 8'($urandom);
            bus.job_nonce_base = $urandom;
            bus.abort = $urandom_range(0, 40) == 0;
            bus.sc_ready = 4'($urandom | $urandom);
            bus.sc_dispatching = 4'($urandom & $urandom);
            bus.sc_evaluating = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            bus.cnt_clear = $urandom_range(0, 200) == 0;
            rst_n = $urandom_range(0, 500) != 0;
            tick();
            checks++;
            if (bus.scan_start !== e_start || (e_start != 0 && (bus.scan_nonce_base !== e_base || bus.scan_job_id !== e_id))) begin
                errors++; $display("FAIL rand_strobe c=%0d got %b/%h/%h exp %b/%h/%h", c, bus.scan_start, bus.scan_nonce_base, bus.scan_job_id, e_start, e_base, e_id);
            end
            checks++;
            if (bus.job_ready !== !m_active || bus.issuing !== m_active ||
                bus.all_idle !== (!m_active && (&bus.sc_ready) && !(|bus.sc_dispatching))) begin
                errors++; $display("FAIL rand_flags c=%0d got ready=%b issuing=%b idle=%b exp active=%b", c, bus.job_ready, bus.issuing, bus.all_idle, m_active);
            end
            checks++;
            if (bus.hash_count !== m_cnt[47:0] || bus2.hash_count !== m_cnt6[5:0] || bus.led_activity !== (m_since < HOLD)) begin
                errors++; $display("FAIL rand_status c=%0d got cnt=%0d cnt6=%0d led=%b exp %0d/%0d/%b", c, bus.hash_count, bus2.hash_count, bus.led_activity, m_cnt, m_cnt6, m_since < HOLD);
            end
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_abort();
        test_hash();
        test_led();
        test_reset_mid_issue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
